// File: rtl/ysyx_24110006_mdu_if.sv
// Request/response bundle between EXU and the multiply/divide unit.
// master = EXU side, slave = MDU side.
interface ysyx_24110006_mdu_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_r;

  modport master (
    output i_valid, i_op, i_a, i_b, i_flush, i_ready,
    input  o_ready, o_valid, o_r
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_flush, i_ready,
    output o_ready, o_valid, o_r
  );
endinterface

// File: rtl/ysyx_24110006_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Define YSYX_24110006_MDU_FAST_MUL_EN for single-cycle multiplies (divide stays iterative).
module ysyx_24110006_mdu #(
  parameter int unsigned XLEN = 32
) (
  input logic                clock,
  input logic                reset,
  ysyx_24110006_mdu_if.slave bus
);
  localparam int unsigned CW = ($clog2(XLEN + 1) > 6) ? $clog2(XLEN + 1) : 6;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next_state;

  logic [2:0]        op;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   divisor;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   r;

  logic              accept, a_signed, b_signed, sa, sb, special, instant;
  logic [XLEN-1:0]   a_mag, b_mag, special_r, instant_r, fin_r;

  always_comb begin
    a_signed  = bus.i_op[2] ? ~bus.i_op[0] : (bus.i_op[1:0] != 2'b11);
    b_signed  = bus.i_op[2] ? ~bus.i_op[0] : ~bus.i_op[1];
    sa        = a_signed & bus.i_a[XLEN-1];
    sb        = b_signed & bus.i_b[XLEN-1];
    a_mag     = sa ? -bus.i_a : bus.i_a;
    b_mag     = sb ? -bus.i_b : bus.i_b;
    special   = 1'b0;
    special_r = '0;
    if (bus.i_op[2]) begin
      if (bus.i_b == '0) begin
        special   = 1'b1;
        special_r = bus.i_op[1] ? bus.i_a : '1;
      end else if (!bus.i_op[0] && bus.i_a == MOST_NEG && bus.i_b == '1) begin
        special   = 1'b1;
        special_r = bus.i_op[1] ? '0 : bus.i_a;
      end
    end
  end

`ifdef YSYX_24110006_MDU_FAST_MUL_EN
  // Sign-extending to 2*XLEN gives the exact (XLEN+1)x(XLEN+1) product modulo 2^(2*XLEN).
  logic signed [2*XLEN-1:0] fa, fb, fprod;
  always_comb begin
    fa        = {{XLEN{sa}}, bus.i_a};
    fb        = {{XLEN{sb}}, bus.i_b};
    fprod     = fa * fb;
    instant   = special | ~bus.i_op[2];
    if (special)
      instant_r = special_r;
    else if (bus.i_op[1:0] == 2'b00)
      instant_r = fprod[XLEN-1:0];
    else
      instant_r = fprod[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    instant   = special;
    instant_r = special_r;
  end
`endif

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [XLEN:0]     sum, rem_sh;
  logic [XLEN-1:0]   diff, quo, rem;
  logic [2*XLEN-1:0] prod;
  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
    rem_sh = acc[2*XLEN-1:XLEN-1];
    diff   = rem_sh[XLEN-1:0] - divisor;
    if (op[2]) begin
      if (rem_sh >= {1'b0, divisor})
        acc_next = {diff, acc[XLEN-2:0], 1'b1};
      else
        acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
    prod = (a_neg ^ b_neg) ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    if (op[2])
      fin_r = op[1] ? (a_neg ? -rem : rem) : ((a_neg ^ b_neg) ? -quo : quo);
    else if (op[1:0] == 2'b00)
      fin_r = prod[XLEN-1:0];
    else
      fin_r = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    bus.o_ready = (state == IDLE);
    bus.o_valid = (state == DONE);
    if (bus.i_flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.i_valid) begin
          accept     = 1'b1;
          next_state = instant ? DONE : BUSY;
        end
        BUSY:    if (cnt == CW'(1)) next_state = DONE;
        DONE:    if (bus.i_ready) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op      <= '0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      divisor <= '0;
      acc     <= '0;
      cnt     <= '0;
      r       <= '0;
    end else if (bus.i_flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op      <= bus.i_op;
          a_neg   <= sa;
          b_neg   <= sb;
          divisor <= b_mag;
          acc     <= {{XLEN{1'b0}}, a_mag};
          cnt     <= CW'(XLEN);
          if (instant) r <= instant_r;
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) r <= fin_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_r = r;
endmodule

// File: tb/tb_ysyx_24110006_mdu.sv
// Scoreboard bench for ysyx_24110006_mdu: directed vectors, latency, backpressure, flush, reset.
module tb_ysyx_24110006_mdu;
  localparam int unsigned XLEN = 32;
`ifdef YSYX_24110006_MDU_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 1;
`else
  localparam int unsigned MUL_LAT = XLEN + 1;
`endif
  localparam int unsigned DIV_LAT = XLEN + 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_24110006_mdu_if #(.XLEN(XLEN)) bus ();
  ysyx_24110006_mdu #(.XLEN(XLEN)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    string       name;
    logic [31:0] r;
    int unsigned vcyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          seen_valid = 1'b0;
  int unsigned cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: first o_valid cycle checks latency, handshake pops and checks the result.
  always @(negedge clock) begin
    if (!reset && bus.o_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: o_valid=1 (o_r=0x%08h) required 0", bus.o_r);
      end else begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          check({sb_q[0].name, "_latency"}, cyc, sb_q[0].vcyc);
        end
        if (bus.i_ready) begin
          check(sb_q[0].name, bus.o_r, sb_q[0].r);
          void'(sb_q.pop_front());
          seen_valid = 1'b0;
        end
      end
    end
  end

  task automatic issue(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] r, int unsigned lat, bit expect_r);
    int unsigned n = 0;
    @(posedge clock); #1;
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    @(negedge clock);
    while (!bus.o_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: o_ready=0 required 1", name);
    end else if (expect_r) begin
      sb_q.push_back('{name, r, cyc + lat});
    end
    @(posedge clock); #1;
    bus.i_valid = 1'b0;
    bus.i_op    = ~op;
    bus.i_a     = ~a;
    bus.i_b     = ~b;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clock);
    while ((sb_q.size() != 0 || !bus.o_ready) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d o_ready=%0b required 0 and 1", sb_q.size(), bus.o_ready);
      sb_q.delete();
      seen_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned vcount;
    bus.i_valid = 1'b0;
    bus.i_op    = '0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    reset       = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_o_ready", 32'(bus.o_ready), 32'd1);
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_o_r", bus.o_r, 32'd0);

    issue("mul_7_m3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b1);
    issue("mul_big",       3'b000, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, MUL_LAT, 1'b1);
    issue("mulh_minneg",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b1);
    issue("mulh_m1_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 1'b1);
    issue("mulhsu_ones",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b1);
    issue("mulhu_ones",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b1);
    issue("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
    issue("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT, 1'b1);
    issue("divu_big_2",    3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, DIV_LAT, 1'b1);
    issue("remu_big_2",    3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, DIV_LAT, 1'b1);
    issue("div_7_m2",      3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
    issue("rem_7_m2",      3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT, 1'b1);
    issue("divu_5_0",      3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1'b1);
    issue("remu_5_0",      3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1, 1'b1);
    issue("div_5_0",       3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1'b1);
    issue("rem_m7_0",      3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1, 1'b1);
    issue("div_overflow",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    issue("rem_overflow",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b1);
    wait_idle();

    // Backpressure: result held for 10 cycles while the next request waits.
    @(posedge clock); #1 bus.i_ready = 1'b0;
    issue("bp_div", 3'b100, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1);
    n = 0;
    @(negedge clock);
    while (!bus.o_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("bp_valid_seen", 32'(bus.o_valid), 32'd1);
    @(posedge clock); #1;
    bus.i_valid = 1'b1;
    bus.i_op    = 3'b000;
    bus.i_a     = 32'd6;
    bus.i_b     = 32'd7;
    repeat (10) begin
      @(negedge clock);
      check("bp_hold_o_r", bus.o_r, 32'd14);
      check("bp_hold_o_ready", 32'(bus.o_ready), 32'd0);
    end
    @(posedge clock); #1 bus.i_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_ready_after", 32'(bus.o_ready), 32'd1);
    check("bp_valid_after", 32'(bus.o_valid), 32'd0);
    sb_q.push_back('{"bp_next_mul", 32'd42, cyc + MUL_LAT});
    @(posedge clock); #1 bus.i_valid = 1'b0;
    wait_idle();

    // Flush in cycle 5 of a divide.
    issue("fl_div", 3'b100, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    repeat (4) begin
      @(posedge clock); #1;
    end
    bus.i_flush = 1'b1;
    @(negedge clock);
    check("fl_busy_o_ready", 32'(bus.o_ready), 32'd0);
    @(posedge clock); #1 bus.i_flush = 1'b0;
    @(negedge clock);
    check("fl_o_ready", 32'(bus.o_ready), 32'd1);
    vcount = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.o_valid) vcount++;
    end
    check("fl_no_valid", vcount, 32'd0);

    // A request coinciding with a flush must not be taken.
    @(posedge clock); #1;
    bus.i_valid = 1'b1;
    bus.i_op    = 3'b000;
    bus.i_a     = 32'd2;
    bus.i_b     = 32'd3;
    bus.i_flush = 1'b1;
    @(posedge clock); #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    @(negedge clock);
    check("fl_req_rejected", 32'(bus.o_ready), 32'd1);
    wait_idle();

    // Reset in cycle 10 of a multiply.
    issue("rs_mul", 3'b000, 32'd5, 32'd6, 32'd0, 0, 1'b0);
    repeat (9) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("rs_o_valid", 32'(bus.o_valid), 32'd0);
    check("rs_o_ready", 32'(bus.o_ready), 32'd1);
    check("rs_o_r", bus.o_r, 32'd0);
    issue("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT, 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
